// File: rtl/regdump_uart_tx.sv
// regdump_uart_tx: captures a register snapshot on START and sends it MSB byte first
// as NUM_BYTES back-to-back UART 8N1 frames on TXD.
module regdump_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [8*NUM_BYTES-1:0] SNAPSHOT,
    output logic                   TXD,
    output logic                   BUSY,
    output logic                   DONE
);
    localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam int SW = 8 * NUM_BYTES;
    typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;
    state_t state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [SW-1:0] buf_q, buf_d;
    logic [7:0] cur_d;
    logic txd_q, txd_d, busy_q, busy_d, done_q, done_d;
    logic baud_end;
    assign baud_end = baud_q == 16'(CLKS_PER_BIT - 1);
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || baud_end) ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                state_d = START_BIT;
                buf_d   = SNAPSHOT;
                byte_d  = '0;
            end
            START_BIT: if (baud_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (baud_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP_BIT;
            end
            STOP_BIT: if (baud_end) begin
                if (byte_q == BW'(NUM_BYTES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    // next byte moves into the top slot of the capture buffer
                    state_d = START_BIT;
                    byte_d  = byte_q + 1'b1;
                    buf_d   = buf_q << 8;
                end
            end
            default: state_d = IDLE;
        endcase
        cur_d  = buf_d[SW-1 -: 8];
        txd_d  = state_d == START_BIT ? 1'b0 : state_d == DATA ? cur_d[bit_d] : 1'b1;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            buf_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            buf_q   <= buf_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign TXD  = txd_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
endmodule

// File: tb/tb_regdump_uart_tx.sv
// tb_regdump_uart_tx: randomized dumps scored by a UART-decoding monitor against
// byte and DONE-time queues filled from a timing model of the dump protocol.
module tb_regdump_uart_tx;
    localparam int C = 4;
    localparam int NB = 32;
    localparam int SW = 8 * NB;
    localparam int DUMP = NB * 10 * C;
    localparam logic [SW-1:0] EXAMPLE = {32'h12345678, 192'h0, 32'hA5A5A5C3};

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [SW-1:0] snap = '0;
    logic txd, busy, done;
    logic start2 = 1'b0;
    logic [7:0] snap2 = '0;
    logic txd2, busy2, done2;
    int n_cmp = 0, n_fail = 0, cyc = 0, model_free = 0, run = 0;
    logic [7:0] exp_q[$];
    int done_q[$];

    regdump_uart_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .SNAPSHOT(snap),
        .TXD(txd), .BUSY(busy), .DONE(done)
    );
    regdump_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(1)) u_min (
        .CLK(clk), .RST(rst), .START(start2), .SNAPSHOT(snap2),
        .TXD(txd2), .BUSY(busy2), .DONE(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [SW-1:0] rand_snap();
        logic [SW-1:0] s;
        for (int i = 0; i < NB / 4; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // The model accepts START only once the previous dump's DONE edge has passed.
    task automatic pulse(input logic [SW-1:0] s);
        start = 1'b1;
        snap = s;
        if (cyc + 1 >= model_free) begin
            for (int i = 0; i < NB; i++) exp_q.push_back(s[8*(NB-1-i) +: 8]);
            done_q.push_back(cyc + 1 + DUMP);
            model_free = cyc + 1 + DUMP + 1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (cyc + 1 < e) @(negedge clk);
    endtask

    task automatic wait_n(input int n, inout logic ok);
        for (int i = 0; i < n && ok; i++) begin
            @(negedge clk);
            #1;
            if (rst) ok = 1'b0;
        end
    endtask

    initial begin : uart_mon
        logic ok;
        logic [7:0] b;
        logic stp;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !txd) begin
                ok = 1'b1;
                b = '0;
                stp = 1'b0;
                wait_n(C / 2, ok);
                if (ok) chk("start_bit", txd, 0);
                for (int j = 0; j < 8 && ok; j++) begin
                    wait_n(C, ok);
                    b[j] = txd;
                end
                wait_n(C, ok);
                stp = txd;
                if (ok) begin
                    chk("frame_expected", longint'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("byte", b, exp_q.pop_front());
                    chk("stop_bit", stp, 1);
                end
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                chk("done_expected", longint'(done_q.size() > 0), 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    initial begin : busy_mon
        forever begin
            @(negedge clk);
            #1;
            if (rst) run = 0;
            else if (busy) run++;
            else if (run != 0) begin
                chk("busy_len", run, DUMP);
                run = 0;
            end
        end
    end

    task automatic min_dump(input logic [7:0] s);
        logic [9:0] seq;
        seq = {1'b1, s, 1'b0};
        start2 = 1'b1;
        snap2 = s;
        @(negedge clk);
        start2 = 1'b0;
        snap2 = ~s;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("min_txd", txd2, seq[i/2]);
            chk("min_busy", busy2, 1);
            chk("min_done", done2, 0);
        end
        @(negedge clk);
        #1;
        chk("min_done_pulse", done2, 1);
        chk("min_busy_end", busy2, 0);
        chk("min_txd_idle", txd2, 1);
        @(negedge clk);
        #1;
        chk("min_done_once", done2, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        logic [SW-1:0] s;
        repeat (20) begin
            @(negedge clk);
            start = 1'($urandom);
            snap = rand_snap();
            start2 = 1'($urandom);
            snap2 = 8'($urandom);
            #1;
            chk("rst_txd", txd, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_txd2", txd2, 1);
        end
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("idle_txd", txd, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        pulse(EXAMPLE);
        wait_edge(model_free + 2);
        s = rand_snap();
        pulse(s);
        snap = '1;
        wait_edge(model_free + 2);
        pulse(rand_snap());
        k = cyc;
        wait_edge(k + 10);
        pulse(rand_snap());
        wait_edge(k + 500);
        pulse(rand_snap());
        wait_edge(k + DUMP);
        pulse(rand_snap());
        pulse(rand_snap());
        wait_edge(model_free + 2);
        pulse(EXAMPLE);
        k = cyc;
        wait_edge(k + 125);
        chk("pre_rst_txd", txd, 0);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        model_free = 0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse(EXAMPLE);
        wait_edge(model_free + 2);
        repeat (2) begin
            wait_edge(cyc + 1 + int'($urandom_range(1, 20)));
            pulse(rand_snap());
            wait_edge(model_free + 1);
        end
        wait_edge(cyc + 3);
        min_dump(8'h01);
        min_dump(8'($urandom));
        min_dump(8'($urandom));
        repeat (10) @(negedge clk);
        chk("bytes_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
